// File: rtl/pwm_pkg.sv
// Shared defaults and drive encodings for the multi-pulse PWM block.
//   Parameter defaults: carrier, triangle, window, step, period, timeout, dead time.
//   Drive codes: PWM_POS = 10, PWM_NEG = 01, PWM_OFF = 00 (11 is never produced).
package pwm_pkg;

    localparam int unsigned CNT_W_DEF   = 28;
    localparam int unsigned TRI_W_DEF   = 15;
    localparam int unsigned NPULSE_DEF  = 3;
    localparam int unsigned DELTA_W_DEF = 22;
    localparam int unsigned PER_W_DEF   = 16;
    localparam int unsigned TIMEOUT_DEF = 50000;
    localparam int unsigned DEAD_DEF    = 20;

    localparam logic [1:0] PWM_POS = 2'b10;
    localparam logic [1:0] PWM_NEG = 2'b01;
    localparam logic [1:0] PWM_OFF = 2'b00;

endpackage

// File: rtl/cycle_edge_sync.sv
// Synchronises the asynchronous cycle command, detects its edges, measures the
// half period between edges and flags a missing-edge timeout.
//   clk          : clock, all logic on posedge
//   rst_n        : synchronous active-low reset
//   cycle        : asynchronous polarity command
//   cyc_edge_c   : combinational edge strobe (c1 xor c2)
//   polarity     : synchronised polarity (c1)
//   half_period  : clocks between the last two edges (saturating)
//   period_valid : one-clock strobe when half_period updates
//   timeout      : no edge seen for TIMEOUT clocks
module cycle_edge_sync
    import pwm_pkg::*;
#(
    parameter int unsigned PER_W   = PER_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cycle,
    output logic             cyc_edge_c,
    output logic             polarity,
    output logic [PER_W-1:0] half_period,
    output logic             period_valid,
    output logic             timeout
);

    localparam logic [PER_W-1:0] TO_LIM = PER_W'(TIMEOUT - 1);

    logic             c1_q, c1_d;
    logic             c2_q, c2_d;
    logic [PER_W-1:0] per_cnt_q, per_cnt_d;
    logic [PER_W-1:0] per_inc_c;
    logic [PER_W-1:0] half_period_q, half_period_d;
    logic             period_valid_q, period_valid_d;
    logic             timeout_q, timeout_d;
    logic             seen_q, seen_d;

    // Next-state: synchroniser, period counter, measurement and timeout.
    always_comb begin
        c1_d           = cycle;
        c2_d           = c1_q;
        cyc_edge_c     = c1_q ^ c2_q;
        per_inc_c      = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + PER_W'(1);
        per_cnt_d      = cyc_edge_c ? '0 : per_inc_c;
        half_period_d  = half_period_q;
        period_valid_d = 1'b0;
        seen_d         = seen_q | cyc_edge_c;
        // The first edge only arms the measurement; there is no prior edge to measure from.
        if (cyc_edge_c && seen_q) begin
            half_period_d  = per_inc_c;
            period_valid_d = 1'b1;
        end
        // An edge on the same clock as the limit keeps the flag clear.
        if (cyc_edge_c) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q | (per_cnt_q >= TO_LIM);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c1_q           <= 1'b0;
            c2_q           <= 1'b0;
            per_cnt_q      <= '0;
            half_period_q  <= '0;
            period_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            seen_q         <= 1'b0;
        end else begin
            c1_q           <= c1_d;
            c2_q           <= c2_d;
            per_cnt_q      <= per_cnt_d;
            half_period_q  <= half_period_d;
            period_valid_q <= period_valid_d;
            timeout_q      <= timeout_d;
            seen_q         <= seen_d;
        end
    end

    assign polarity     = c1_q;
    assign half_period  = half_period_q;
    assign period_valid = period_valid_q;
    assign timeout      = timeout_q;

endmodule

// File: rtl/multi_pulse_pwm.sv
// Multi-pulse PWM: a folding triangle carrier restarted on every cycle edge is
// compared against NPULSE on/off windows; hits drive the pulse of the current
// polarity, blanked for DEAD clocks after each edge and while timed out.
//   clk100MHz    : clock, all logic on posedge
//   rst_n        : synchronous active-low reset
//   cycle        : asynchronous polarity command (1 positive, 0 negative half)
//   enable       : 0 forces no pulse
//   delta        : carrier step per clock, latched on each edge
//   thr          : packed on/off thresholds per window, latched on each edge
//   pwm_drive    : 10 positive, 01 negative, 00 none
//   half_period  : clocks between the last two cycle edges
//   period_valid : strobe when half_period updates
//   timeout      : missing-edge fault
module multi_pulse_pwm
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned TRI_W   = TRI_W_DEF,
    parameter int unsigned NPULSE  = NPULSE_DEF,
    parameter int unsigned DELTA_W = DELTA_W_DEF,
    parameter int unsigned PER_W   = PER_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned DEAD    = DEAD_DEF
) (
    input  logic                        clk100MHz,
    input  logic                        rst_n,
    input  logic                        cycle,
    input  logic                        enable,
    input  logic [DELTA_W-1:0]          delta,
    input  logic [2*NPULSE*TRI_W-1:0]   thr,
    output logic [1:0]                  pwm_drive,
    output logic [PER_W-1:0]            half_period,
    output logic                        period_valid,
    output logic                        timeout
);

    localparam int unsigned THR_W  = 2 * NPULSE * TRI_W;
    localparam int unsigned DEAD_W = (DEAD > 0) ? $clog2(DEAD + 1) : 1;

    logic                cyc_edge_c;
    logic                polarity;

    logic [CNT_W-1:0]    count_q, count_d;
    logic                down_q, down_d;
    logic [DELTA_W-1:0]  delta_sh_q, delta_sh_d;
    logic [THR_W-1:0]    thr_sh_q, thr_sh_d;
    logic                s0_q, s0_d;
    logic                s1_q, s1_d;
    logic [DEAD_W-1:0]   dead_q, dead_d;
    logic [1:0]          drive_q, drive_d;

    logic [CNT_W-1:0]    sum_c;
    logic [TRI_W-1:0]    triangle_c;
    logic                win_hit_c;
    logic                ok_c;

    cycle_edge_sync #(
        .PER_W   (PER_W),
        .TIMEOUT (TIMEOUT)
    ) u_sync (
        .clk          (clk100MHz),
        .rst_n        (rst_n),
        .cycle        (cycle),
        .cyc_edge_c   (cyc_edge_c),
        .polarity     (polarity),
        .half_period  (half_period),
        .period_valid (period_valid),
        .timeout      (timeout)
    );

    // Carrier, window compare, dead-time and drive next-state.
    always_comb begin
        count_d    = count_q;
        down_d     = down_q;
        delta_sh_d = delta_sh_q;
        thr_sh_d   = thr_sh_q;
        triangle_c = count_q[CNT_W-1 -: TRI_W];
        sum_c      = down_q ? count_q - CNT_W'(delta_sh_q) : count_q + CNT_W'(delta_sh_q);
        win_hit_c  = 1'b0;

        if (cyc_edge_c) begin
            count_d    = '0;
            down_d     = 1'b0;
            delta_sh_d = delta;
            thr_sh_d   = thr;
        end else if (!timeout) begin
            // Crossing the fold point reflects the sum; both folds reduce to negation mod 2^CNT_W.
            if (!sum_c[CNT_W-1]) begin
                count_d = sum_c;
            end else begin
                count_d = CNT_W'(0) - sum_c;
                down_d  = ~down_q;
            end
        end

        // A window with on >= off can never satisfy on <= tri < off, so it is disabled.
        for (int unsigned k = 0; k < NPULSE; k++) begin
            if ((thr_sh_q[(2*k)*TRI_W +: TRI_W] <= triangle_c) &&
                (triangle_c < thr_sh_q[(2*k+1)*TRI_W +: TRI_W])) begin
                win_hit_c = 1'b1;
            end
        end

        s0_d = win_hit_c;
        s1_d = polarity;

        if (cyc_edge_c) begin
            dead_d = DEAD_W'(DEAD);
        end else if (dead_q != '0) begin
            dead_d = dead_q - DEAD_W'(1);
        end else begin
            dead_d = dead_q;
        end

        ok_c    = enable & ~timeout & (dead_q == '0);
        drive_d = PWM_OFF;
        if (s0_q && ok_c) begin
            drive_d = s1_q ? PWM_POS : PWM_NEG;
        end
    end

    always_ff @(posedge clk100MHz) begin
        if (!rst_n) begin
            count_q    <= '0;
            down_q     <= 1'b0;
            delta_sh_q <= delta;
            thr_sh_q   <= thr;
            s0_q       <= 1'b0;
            s1_q       <= 1'b0;
            dead_q     <= '0;
            drive_q    <= PWM_OFF;
        end else begin
            count_q    <= count_d;
            down_q     <= down_d;
            delta_sh_q <= delta_sh_d;
            thr_sh_q   <= thr_sh_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            dead_q     <= dead_d;
            drive_q    <= drive_d;
        end
    end

    assign pwm_drive = drive_q;

endmodule

// File: tb/tb_multi_pulse_pwm.sv
// Bench for multi_pulse_pwm: cycle-level reference model feeding a scoreboard,
// a table of window/slope vectors with hand-derived pulse counts, and directed
// sequences for mid-cycle delta change, period measurement, reset and timeout.
module tb_multi_pulse_pwm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc;
    logic        enable;
    logic [21:0] delta;
    logic [89:0] thr;
    logic [1:0]  pwm_drive;
    logic [15:0] half_period;
    logic        period_valid;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [1:0]  drv;
        logic [15:0] hp;
        logic        pv;
        logic        to;
    } obs_t;

    obs_t sb_q[$];

    typedef struct {
        int unsigned dlt;
        int unsigned on0, off0, on1, off1;
        bit          en;
        bit          pol;
        int unsigned exp_pos, exp_neg;
    } vec_t;

    vec_t vt [8];

    // reference model state
    bit              m_c1 = 0, m_c2 = 0, m_down = 0, m_s0 = 0, m_s1 = 0;
    bit              m_seen = 0, m_pv = 0, m_to = 0;
    int unsigned     m_dead = 0, m_per = 0, m_hp = 0, m_drv = 0;
    longint unsigned m_count = 0, m_dsh = 0;
    logic [89:0]     m_thr = '0;

    multi_pulse_pwm dut (
        .clk100MHz    (clk),
        .rst_n        (rst_n),
        .cycle        (cyc),
        .enable       (enable),
        .delta        (delta),
        .thr          (thr),
        .pwm_drive    (pwm_drive),
        .half_period  (half_period),
        .period_valid (period_valid),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model across one posedge using the inputs currently driven.
    task automatic model_step(output obs_t e);
        bit              ev, hit, ok;
        longint unsigned tv, s;
        if (!rst_n) begin
            m_c1 = 0; m_c2 = 0; m_count = 0; m_down = 0; m_s0 = 0; m_s1 = 0;
            m_dead = 0; m_per = 0; m_hp = 0; m_seen = 0; m_pv = 0; m_to = 0;
            m_drv = 0; m_dsh = longint'(delta); m_thr = thr;
        end else begin
            ev  = (m_c1 != m_c2);
            tv  = m_count >> 13;
            hit = 0;
            for (int k = 0; k < 3; k++) begin
                if (m_thr[30*k +: 15] <= tv && tv < m_thr[30*k+15 +: 15]) hit = 1;
            end
            ok    = enable && !m_to && (m_dead == 0);
            m_drv = (m_s0 && ok) ? (m_s1 ? 2 : 1) : 0;
            m_s1  = m_c1;
            m_s0  = hit;
            if (ev) begin
                m_count = 0; m_down = 0; m_dsh = longint'(delta); m_thr = thr;
            end else if (!m_to) begin
                s = (m_down ? m_count - m_dsh : m_count + m_dsh) & 64'h0FFF_FFFF;
                if (s < 64'h0800_0000) begin
                    m_count = s;
                end else begin
                    m_count = (64'h1000_0000 - s) & 64'h0FFF_FFFF;
                    m_down  = !m_down;
                end
            end
            m_dead = ev ? 20 : ((m_dead > 0) ? m_dead - 1 : 0);
            m_pv   = ev && m_seen;
            if (m_pv) m_hp = (m_per >= 65535) ? 65535 : m_per + 1;
            m_seen = m_seen || ev;
            m_to   = ev ? 0 : (m_to || (m_per >= 49999));
            m_per  = ev ? 0 : ((m_per >= 65535) ? 65535 : m_per + 1);
            m_c2   = m_c1;
            m_c1   = cyc;
        end
        e.drv = 2'(m_drv);
        e.hp  = 16'(m_hp);
        e.pv  = m_pv;
        e.to  = m_to;
    endtask

    // One clock: push the model's expectation, then compare at the falling edge.
    task automatic tick();
        obs_t e, a;
        model_step(e);
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        a = {pwm_drive, half_period, period_valid, timeout};
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty at t=%0t", $time);
        end else begin
            e = sb_q.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle_compare t=%0t got drv=%b hp=%0d pv=%b to=%b expected drv=%b hp=%0d pv=%b to=%b",
                         $time, a.drv, a.hp, a.pv, a.to, e.drv, e.hp, e.pv, e.to);
            end
        end
    endtask

    task automatic set_thr(input int unsigned on0, off0, on1, off1);
        thr = '0;
        thr[0  +: 15] = 15'(on0);
        thr[15 +: 15] = 15'(off0);
        thr[30 +: 15] = 15'(on1);
        thr[45 +: 15] = 15'(off1);
    endtask

    // Start a half cycle of polarity pol and count pulse clocks from the 25th clock on.
    task automatic run_half(input int unsigned dlt, input int unsigned mid_dlt, input bit pol,
                            output int unsigned npos, output int unsigned nneg);
        delta = 22'(dlt);
        if (cyc == pol) begin
            cyc = ~pol;
            repeat (5) tick();
        end
        cyc  = pol;
        npos = 0;
        nneg = 0;
        for (int i = 0; i < 270; i++) begin
            if (i == 10) delta = 22'(mid_dlt);
            tick();
            if (i >= 25 && pwm_drive == 2'b10) npos++;
            if (i >= 25 && pwm_drive == 2'b01) nneg++;
        end
    endtask

    initial begin
        int unsigned np, nn, pv_n;
        bit          found;

        vt[0] = '{32'h10_0000,  4096,  8192,     0,     0, 1'b1, 1'b1, 64,   0};
        vt[1] = '{32'h10_0000,  4096,  8192,     0,     0, 1'b1, 1'b0,  0,  64};
        vt[2] = '{32'h10_0000,  4096,  8192, 10000, 12000, 1'b1, 1'b1, 94,   0};
        vt[3] = '{32'h08_0000,  4096,  8192,     0,     0, 1'b1, 1'b0,  0,  64};
        vt[4] = '{32'h10_0000, 16000, 20000,     0,     0, 1'b1, 1'b1,  7,   0};
        vt[5] = '{32'h10_0000,  4096,  8192,     0,     0, 1'b0, 1'b0,  0,   0};
        vt[6] = '{32'h10_0000,  8192,  8192,  9000,  4000, 1'b1, 1'b1,  0,   0};
        vt[7] = '{32'h00_0000,     0,   100,     0,     0, 1'b1, 1'b0,  0, 245};

        rst_n  = 1'b0;
        cyc    = 1'b0;
        enable = 1'b1;
        delta  = '0;
        thr    = '0;
        @(negedge clk);
        repeat (3) tick();
        chk("reset_drive", pwm_drive, 0);
        chk("reset_half_period", half_period, 0);
        chk("reset_period_valid", period_valid, 0);
        chk("reset_timeout", timeout, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // window / slope table
        for (int v = 0; v < 8; v++) begin
            enable = vt[v].en;
            set_thr(vt[v].on0, vt[v].off0, vt[v].on1, vt[v].off1);
            run_half(vt[v].dlt, vt[v].dlt, vt[v].pol, np, nn);
            chk($sformatf("vec%0d_pos_clocks", v), np, vt[v].exp_pos);
            chk($sformatf("vec%0d_neg_clocks", v), nn, vt[v].exp_neg);
        end

        // delta change mid half-cycle takes effect only at the next edge
        enable = 1'b1;
        set_thr(4096, 8192, 10000, 12000);
        run_half(32'h10_0000, 32'h08_0000, ~cyc, np, nn);
        chk("delta_mid_old_slope", np + nn, 94);
        run_half(32'h08_0000, 32'h08_0000, ~cyc, np, nn);
        chk("delta_next_new_slope", np + nn, 95);

        // period measurement with edges 1000 clocks apart, starting fresh from reset
        delta = 22'h10_0000;
        set_thr(4096, 8192, 0, 0);
        cyc   = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        pv_n  = 0;
        for (int e = 0; e < 5; e++) begin
            cyc = ~cyc;
            for (int i = 0; i < 1000; i++) begin
                tick();
                if (period_valid) begin
                    pv_n++;
                    chk("half_period_1000", half_period, 1000);
                end
            end
        end
        chk("period_valid_strobes", pv_n, 4);

        // reset during an active pulse
        found = 0;
        for (int n = 0; n < 400 && !found; n++) begin
            tick();
            if (pwm_drive != 2'b00) found = 1;
        end
        chk("pulse_before_reset", found, 1);
        rst_n = 1'b0;
        tick();
        chk("reset_mid_pulse_drive", pwm_drive, 0);
        rst_n = 1'b1;
        pv_n  = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (period_valid) pv_n++;
        end
        chk("no_strobe_first_edge_after_reset", pv_n, 0);
        cyc  = ~cyc;
        pv_n = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (period_valid) pv_n++;
        end
        chk("strobe_second_edge_after_reset", pv_n, 1);

        // missing edge: timeout, blanked output, then recovery from count 0
        set_thr(4096, 8192, 10000, 12000);
        cyc = ~cyc;
        repeat (50010) tick();
        chk("timeout_set", timeout, 1);
        chk("timeout_drive_off", pwm_drive, 0);
        run_half(32'h10_0000, 32'h10_0000, ~cyc, np, nn);
        chk("timeout_cleared", timeout, 0);
        chk("restart_pulse_clocks", np + nn, 94);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_pulse_pwm.md
MULTI_PULSE_PWM -- requirements
Module: multi_pulse_pwm

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- CNT_W, 28: carrier accumulator width; fold point 2^(CNT_W-1).
- TRI_W, 15: triangle width, triangle = count[CNT_W-1:CNT_W-TRI_W].
- NPULSE, 3: pulse windows per half cycle, legal 1..8.
- DELTA_W, 22: carrier step width, DELTA_W <= CNT_W-2.
- PER_W, 16: half-period measurement width.
- TIMEOUT, 50000: clocks without a cycle edge before fault.
- DEAD, 20: clocks of forced 00 output after each cycle edge.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk100MHz, in, 1: single clock, all logic on posedge.
- rst_n, in, 1: synchronous, active-low reset.
- cycle, in, 1: asynchronous switching command, 1 = positive half, 0 = negative half.
- enable, in, 1: 0 forces no pulse.
- delta, in, DELTA_W: carrier step per clock.
- thr, in, 2*NPULSE*TRI_W: window k: on_k = bits [(2k)*TRI_W +: TRI_W], off_k = bits [(2k+1)*TRI_W +: TRI_W].
- pwm_drive, out, 2: 10 positive pulse, 01 negative pulse, 00 none; 11 never driven.
- half_period, out, PER_W: clocks between the last two cycle edges.
- period_valid, out, 1: one-clock strobe when half_period updates.
- timeout, out, 1: missing-edge fault flag.

Function
REQ-003 cycle SHALL pass two flops (c1, c2); edge = c1 XOR c2; the polarity bit is c1.
REQ-004 On an edge clock, count <= 0, down <= 0, and delta_sh/thr_sh <= delta/thr; the shadows are otherwise held, so mid-half-cycle input changes have no effect.
REQ-005 Otherwise, sum = down ? count-delta_sh : count+delta_sh, computed in CNT_W bits.
- If sum[CNT_W-1] = 0: count <= sum.
- If sum[CNT_W-1] = 1 and down = 0 (top fold): count <= 2^CNT_W - sum, down <= 1.
- If sum[CNT_W-1] = 1 and down = 1 (bottom fold): count <= -sum (two's complement), down <= 0.
REQ-006 With delta_sh = 0, count SHALL hold.
REQ-007 Window k SHALL be active when on_k <= triangle < off_k (unsigned); on_k >= off_k disables window k.
REQ-008 S0 <= OR of all active windows; S1 <= c1; both registered, one clock after the count state they use.
REQ-009 pwm_drive SHALL be registered: {S1&S0&ok, ~S1&S0&ok}, where ok = enable & ~timeout & (dead_cnt = 0).
REQ-010 dead_cnt SHALL load DEAD on an edge and decrement to 0; DEAD = 0 means no blanking.
REQ-011 per_cnt SHALL clear on an edge and otherwise increment, saturating at all-ones.
REQ-012 On an edge, half_period <= per_cnt+1 (saturating) and period_valid pulses for one clock, but only if an edge has already occurred since reset; the first edge produces no strobe.
REQ-013 timeout SHALL set when per_cnt reaches TIMEOUT-1 and clear on the next edge; while set, count and down freeze.
REQ-014 An edge coinciding with timeout assertion SHALL win: timeout stays 0.

Reset
REQ-015 While rst_n = 0 at a clock edge: count, down, c1, c2, S, dead_cnt, per_cnt, half_period and the edge-seen flag go to 0; pwm_drive = 00, period_valid = 0, timeout = 0; shadows load the current delta/thr.
REQ-016 Reset asserted mid-pulse SHALL drive pwm_drive to 00 on the next clock; after release, the first edge is treated as in REQ-012.

Structure
REQ-017 Package pwm_pkg SHALL hold the parameter defaults and the drive encodings (PWM_POS = 10, PWM_NEG = 01, PWM_OFF = 00).
REQ-018 Sub-module cycle_edge_sync SHALL contain the synchronizer, edge detect, per_cnt, half_period/period_valid and timeout; the carrier and compare logic stay in multi_pulse_pwm.

Verification
REQ-019 Run with the defaults and the following directed scenarios:
- delta = 2^20, cycle held constant after one edge -> triangle rises by 128 per clock, peaks at 16384 at clock 128, then falls; bottom fold at clock 256.
- cycle = 1, window0 = [4096, 8192), others disabled, DEAD = 0 -> pwm_drive = 10 for 32 clocks on the up slope and 32 on the down slope, one clock after triangle crosses.
- cycle toggled every 1000 clocks -> period_valid from the 2nd edge on, half_period = 1000, polarity alternates 10/01, first 20 clocks after each edge = 00.
- delta changed mid-half-cycle -> slope is unchanged until the next edge, then uses the new value.
- cycle stuck for 50000 clocks -> timeout = 1, pwm_drive = 00, count frozen; the next edge clears timeout and restarts count from 0.
- rst_n low for 1 clock during an active pulse -> pwm_drive = 00 the next clock; no period_valid on the first edge after reset.
